// File: rtl/scariv_bru_pkg.sv
// Shared BRU definitions: branch-update queue entry layout and the commit-id age ordering.
package scariv_bru_pkg;

  localparam int unsigned CMT_ID_W = 6;
  localparam int unsigned GRP_W    = 4;
  localparam int unsigned VADDR_W  = 39;
  localparam int unsigned BHR_W    = 16;

  typedef struct packed {
    logic                valid;
    logic [CMT_ID_W-1:0] cmt_id;
    logic [GRP_W-1:0]    grp_id;
    logic [VADDR_W-1:0]  pc;
    logic [VADDR_W-1:0]  target;
    logic                taken;
    logic                is_cond;
    logic                mispred;
    logic [BHR_W-1:0]    bhr;
  } br_upd_entry_t;

  // MSB of cmt_id is the ROB wrap bit; inside one group the lower slot is older.
  function automatic logic is_older(input logic [CMT_ID_W-1:0] cmt_a,
                                    input logic [GRP_W-1:0]    grp_a,
                                    input logic [CMT_ID_W-1:0] cmt_b,
                                    input logic [GRP_W-1:0]    grp_b);
    logic                wrap_eq;
    logic [CMT_ID_W-2:0] idx_a;
    logic [CMT_ID_W-2:0] idx_b;
    wrap_eq = (cmt_a[CMT_ID_W-1] == cmt_b[CMT_ID_W-1]);
    idx_a   = cmt_a[CMT_ID_W-2:0];
    idx_b   = cmt_b[CMT_ID_W-2:0];
    if (cmt_a == cmt_b) begin
      return grp_a < grp_b;
    end
    return wrap_eq ? (idx_a < idx_b) : (idx_a > idx_b);
  endfunction

endpackage

// File: rtl/scariv_br_upd_age_cmp.sv
// Combinational age comparator: a_older_o is set when (cmt_a, grp_a) is older than (cmt_b, grp_b).
module scariv_br_upd_age_cmp
  import scariv_bru_pkg::*;
(
  input  logic [CMT_ID_W-1:0] cmt_a_i,
  input  logic [GRP_W-1:0]    grp_a_i,
  input  logic [CMT_ID_W-1:0] cmt_b_i,
  input  logic [GRP_W-1:0]    grp_b_i,
  output logic                a_older_o
);

  assign a_older_o = is_older(cmt_a_i, grp_a_i, cmt_b_i, grp_b_i);

endmodule

// File: rtl/scariv_br_upd_queue.sv
// Branch-update queue: buffers BRU ex3 resolutions and replays them in order to the predictor,
// dropping entries squashed by younger-path flushes.
module scariv_br_upd_queue
  import scariv_bru_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,

  input  logic                     i_upd_valid,
  input  logic [CMT_ID_W-1:0]      i_upd_cmt_id,
  input  logic [GRP_W-1:0]         i_upd_grp_id,
  input  logic [VADDR_W-1:0]       i_upd_pc_vaddr,
  input  logic [VADDR_W-1:0]       i_upd_target_vaddr,
  input  logic                     i_upd_taken,
  input  logic                     i_upd_is_cond,
  input  logic                     i_upd_mispred,
  input  logic [BHR_W-1:0]         i_upd_bhr,

  input  logic                     i_flush_valid,
  input  logic                     i_flush_all,
  input  logic [CMT_ID_W-1:0]      i_flush_cmt_id,
  input  logic [GRP_W-1:0]         i_flush_grp_id,

  output logic                     o_pu_valid,
  input  logic                     i_pu_ready,
  output logic [VADDR_W-1:0]       o_pu_pc_vaddr,
  output logic [VADDR_W-1:0]       o_pu_target_vaddr,
  output logic                     o_pu_taken,
  output logic                     o_pu_is_cond,
  output logic                     o_pu_mispred,
  output logic [BHR_W-1:0]         o_pu_bhr,

  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  br_upd_entry_t entries_q [DEPTH];
  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;
  logic          overflow_q;

  logic          full;
  logic          empty;
  br_upd_entry_t head_ent;
  logic          pop;
  logic          skip;
  logic          flush_all;
  logic          flush_part;
  logic          upd_younger;
  logic          push;
  logic [DEPTH-1:0] ent_younger;

  assign full  = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign empty = (head_q == tail_q);

  assign head_ent = entries_q[head_q[AW-1:0]];
  assign pop      = o_pu_valid && i_pu_ready;
  assign skip     = !empty && !head_ent.valid;

  assign flush_all  = i_flush_valid && i_flush_all;
  assign flush_part = i_flush_valid && !i_flush_all;

  scariv_br_upd_age_cmp u_upd_age (
    .cmt_a_i   (i_flush_cmt_id),
    .grp_a_i   (i_flush_grp_id),
    .cmt_b_i   (i_upd_cmt_id),
    .grp_b_i   (i_upd_grp_id),
    .a_older_o (upd_younger)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    scariv_br_upd_age_cmp u_ent_age (
      .cmt_a_i   (i_flush_cmt_id),
      .grp_a_i   (i_flush_grp_id),
      .cmt_b_i   (entries_q[i].cmt_id),
      .grp_b_i   (entries_q[i].grp_id),
      .a_older_o (ent_younger[i])
    );
  end

  // A full queue stays full for this cycle even if the head pops.
  assign push = i_upd_valid && !full && !flush_all && !(flush_part && upd_younger);

  always_comb begin
    head_d = head_q;
    if (pop || skip) begin
      head_d = head_q + {{AW{1'b0}}, 1'b1};
    end
    tail_d = tail_q;
    if (flush_all) begin
      // Track head_d so a pop completing alongside the flush leaves the queue empty.
      tail_d = head_d;
    end else if (push) begin
      tail_d = tail_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (i_upd_valid && full) begin
        overflow_q <= 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_all || (flush_part && ent_younger[i])) begin
          entries_q[i].valid <= 1'b0;
        end
      end
      if (push) begin
        entries_q[tail_q[AW-1:0]] <= '{valid:   1'b1,
                                       cmt_id:  i_upd_cmt_id,
                                       grp_id:  i_upd_grp_id,
                                       pc:      i_upd_pc_vaddr,
                                       target:  i_upd_target_vaddr,
                                       taken:   i_upd_taken,
                                       is_cond: i_upd_is_cond,
                                       mispred: i_upd_mispred,
                                       bhr:     i_upd_bhr};
      end
    end
  end

  assign o_pu_valid        = head_ent.valid && !empty;
  assign o_pu_pc_vaddr     = head_ent.pc;
  assign o_pu_target_vaddr = head_ent.target;
  assign o_pu_taken        = head_ent.taken;
  assign o_pu_is_cond      = head_ent.is_cond;
  assign o_pu_mispred      = head_ent.mispred;
  assign o_pu_bhr          = head_ent.bhr;

  assign o_count    = tail_q - head_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_scariv_br_upd_queue.sv
// Directed bench for scariv_br_upd_queue: push/pop, overflow, partial and full flush, wrap, reset.
module tb_scariv_br_upd_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        upd_valid;
  logic [5:0]  upd_cmt_id;
  logic [3:0]  upd_grp_id;
  logic [38:0] upd_pc;
  logic [38:0] upd_target;
  logic        upd_taken;
  logic        upd_is_cond;
  logic        upd_mispred;
  logic [15:0] upd_bhr;
  logic        flush_valid;
  logic        flush_all;
  logic [5:0]  flush_cmt_id;
  logic [3:0]  flush_grp_id;
  logic        pu_valid;
  logic        pu_ready;
  logic [38:0] pu_pc;
  logic [38:0] pu_target;
  logic        pu_taken;
  logic        pu_is_cond;
  logic        pu_mispred;
  logic [15:0] pu_bhr;
  logic [3:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scariv_br_upd_queue #(.DEPTH(8)) dut (
    .i_clk              (clk),
    .i_reset_n          (reset_n),
    .i_upd_valid        (upd_valid),
    .i_upd_cmt_id       (upd_cmt_id),
    .i_upd_grp_id       (upd_grp_id),
    .i_upd_pc_vaddr     (upd_pc),
    .i_upd_target_vaddr (upd_target),
    .i_upd_taken        (upd_taken),
    .i_upd_is_cond      (upd_is_cond),
    .i_upd_mispred      (upd_mispred),
    .i_upd_bhr          (upd_bhr),
    .i_flush_valid      (flush_valid),
    .i_flush_all        (flush_all),
    .i_flush_cmt_id     (flush_cmt_id),
    .i_flush_grp_id     (flush_grp_id),
    .o_pu_valid         (pu_valid),
    .i_pu_ready         (pu_ready),
    .o_pu_pc_vaddr      (pu_pc),
    .o_pu_target_vaddr  (pu_target),
    .o_pu_taken         (pu_taken),
    .o_pu_is_cond       (pu_is_cond),
    .o_pu_mispred       (pu_mispred),
    .o_pu_bhr           (pu_bhr),
    .o_count            (count),
    .o_overflow         (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_upd(input logic [5:0] cmt, input logic [38:0] pc);
    upd_valid   = 1'b1;
    upd_cmt_id  = cmt;
    upd_grp_id  = 4'b0001;
    upd_pc      = pc;
    upd_target  = pc + 39'h40;
    upd_taken   = cmt[0];
    upd_is_cond = 1'b1;
    upd_mispred = 1'b0;
    upd_bhr     = {10'h0, cmt};
  endtask

  task automatic push(input logic [5:0] cmt, input logic [38:0] pc);
    drive_upd(cmt, pc);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic flush(input logic all, input logic [5:0] cmt, input logic [3:0] grp);
    flush_valid  = 1'b1;
    flush_all    = all;
    flush_cmt_id = cmt;
    flush_grp_id = grp;
  endtask

  initial begin
    reset_n = 1'b0;
    upd_valid = 1'b0; upd_cmt_id = '0; upd_grp_id = '0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_is_cond = 1'b0; upd_mispred = 1'b0; upd_bhr = '0;
    flush_valid = 1'b0; flush_all = 1'b0; flush_cmt_id = '0; flush_grp_id = '0;
    pu_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(pu_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_pc", 64'(pu_pc), 64'd0);
    reset_n = 1'b1;

    // Single push, one-cycle latency, then pop
    pu_ready = 1'b1;
    push(6'd5, 39'h0_8000_0100);
    check("single_valid", 64'(pu_valid), 64'd1);
    check("single_pc", 64'(pu_pc), 64'h8000_0100);
    check("single_target", 64'(pu_target), 64'h8000_0140);
    check("single_taken", 64'(pu_taken), 64'd1);
    check("single_bhr", 64'(pu_bhr), 64'h5);
    check("single_count", 64'(count), 64'd1);
    tick();
    check("single_drained_count", 64'(count), 64'd0);
    check("single_drained_valid", 64'(pu_valid), 64'd0);

    // Fill to full and overflow on the 9th push
    pu_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(6'(i), 39'h1000 + 39'(4 * i));
    check("full_count", 64'(count), 64'd8);
    check("full_no_overflow", 64'(overflow), 64'd0);
    push(6'd8, 39'h1020);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
    pu_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 64'(pu_valid), 64'd1);
      check("drain_pc", 64'(pu_pc), 64'h1000 + 64'(4 * k));
      tick();
    end
    check("drain_empty_count", 64'(count), 64'd0);
    check("drain_empty_valid", 64'(pu_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Partial flush at cmt 4 squashes 5 and 6, and a younger same-cycle push
    pu_ready = 1'b0;
    for (int i = 3; i < 7; i++) push(6'(i), 39'h2000 + 39'(i));
    flush(1'b0, 6'd4, 4'b0001);
    drive_upd(6'd7, 39'h2007);
    tick();
    flush_valid = 1'b0;
    upd_valid   = 1'b0;
    check("pflush_count", 64'(count), 64'd4);
    pu_ready = 1'b1;
    check("pflush_h3_valid", 64'(pu_valid), 64'd1);
    check("pflush_h3_pc", 64'(pu_pc), 64'h2003);
    tick();
    check("pflush_h4_valid", 64'(pu_valid), 64'd1);
    check("pflush_h4_pc", 64'(pu_pc), 64'h2004);
    check("pflush_h4_count", 64'(count), 64'd3);
    tick();
    check("pflush_skip1_valid", 64'(pu_valid), 64'd0);
    check("pflush_skip1_count", 64'(count), 64'd2);
    tick();
    check("pflush_skip2_valid", 64'(pu_valid), 64'd0);
    check("pflush_skip2_count", 64'(count), 64'd1);
    tick();
    check("pflush_empty_count", 64'(count), 64'd0);

    // Wrap-bit age ordering: flush at 0x3F kills 0x00 and 0x01
    pu_ready = 1'b0;
    push(6'h3E, 39'h3000);
    push(6'h3F, 39'h3001);
    push(6'h00, 39'h3002);
    push(6'h01, 39'h3003);
    flush(1'b0, 6'h3F, 4'b0001);
    tick();
    flush_valid = 1'b0;
    pu_ready = 1'b1;
    check("wrap_h0_pc", 64'(pu_pc), 64'h3000);
    check("wrap_h0_valid", 64'(pu_valid), 64'd1);
    tick();
    check("wrap_h1_pc", 64'(pu_pc), 64'h3001);
    check("wrap_h1_valid", 64'(pu_valid), 64'd1);
    tick();
    check("wrap_sq0_valid", 64'(pu_valid), 64'd0);
    check("wrap_sq0_count", 64'(count), 64'd2);
    tick();
    check("wrap_sq1_valid", 64'(pu_valid), 64'd0);
    tick();
    check("wrap_empty_count", 64'(count), 64'd0);

    // Flush-all with a simultaneous push
    pu_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(6'(10 + i), 39'h4000 + 39'(i));
    check("fall_pre_count", 64'(count), 64'd5);
    flush(1'b1, 6'd0, 4'b0001);
    drive_upd(6'd20, 39'h0DEAD);
    tick();
    flush_valid = 1'b0;
    flush_all   = 1'b0;
    upd_valid   = 1'b0;
    check("fall_count", 64'(count), 64'd0);
    check("fall_valid", 64'(pu_valid), 64'd0);
    push(6'd21, 39'h5000);
    check("fall_after_valid", 64'(pu_valid), 64'd1);
    check("fall_after_pc", 64'(pu_pc), 64'h5000);
    check("fall_after_count", 64'(count), 64'd1);
    pu_ready = 1'b1;
    tick();
    check("fall_after_drain", 64'(count), 64'd0);

    // Reset in the middle of a drain
    pu_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(6'(30 + i), 39'h6100 + 39'(i));
    pu_ready = 1'b1;
    tick();
    check("mid_count", 64'(count), 64'd2);
    reset_n = 1'b0;
    tick();
    check("mrst_valid", 64'(pu_valid), 64'd0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    push(6'd7, 39'h6000);
    check("mrst_push_valid", 64'(pu_valid), 64'd1);
    check("mrst_push_pc", 64'(pu_pc), 64'h6000);
    check("mrst_push_count", 64'(count), 64'd1);
    tick();
    check("mrst_push_drain", 64'(count), 64'd0);
    check("mrst_push_drain_valid", 64'(pu_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
